pe_array_nxn: RTL and testbench
===============================

// Module: pe_array_nxn
// PURPOSE
//  Parametrised DIMxDIM output-stationary systolic matrix-multiply array, C = A*B, all operands DIMxDIM.
//  Operands stream in one k-beat per handshake: column k of A and row k of B.
//  Internal skew registers diagonalise the operands into a grid of MAC cells.
//  Results drain one C row per beat over a valid/ready port. One matrix in flight.
// PARAMETERS
//  DIM    4                          array rows/cols and number of k-beats per matrix (>=2)
//  WIDTH  8                          operand width, bits
//  ACC_W  2*WIDTH+$clog2(DIM)+1      accumulator/result width; one guard bit over the exact worst-case sum
// PORTS
//  clk     in   1                clock, all state on rising edge
//  rst_n   in   1                reset, asynchronous assert, active-low
//  a_in    in   [DIM][WIDTH]     A column k; a_in[i] = A[i][k]
//  b_in    in   [DIM][WIDTH]     B row k; b_in[j] = B[k][j]
//  in_val  in   1                input beat valid
//  in_rdy  out  1                input beat accepted when in_val&&in_rdy
//  c_out   out  [DIM][ACC_W]     C row r; c_out[j] = C[r][j]
//  c_row   out  $clog2(DIM)      row index r of c_out
//  c_val   out  1                output row valid
//  c_rdy   in   1                output row taken when c_val&&c_rdy
//  busy    out  1                high in any state but IDLE
// BEHAVIOUR
//  Reset values: in_rdy=0, c_val=0, c_out=0, c_row=0, busy=0. All accumulators, skew regs, counters and tags clear.
//  FSM states (pe_array_pkg::state_t):
//   IDLE   in_rdy=1. First accepted beat -> LOAD with kcnt=1.
//   LOAD   in_rdy=1. Each accepted beat does kcnt++. Acceptance with kcnt==DIM-1 -> FLUSH, fcnt=0.
//   FLUSH  in_rdy=0. fcnt counts 2*DIM-1 cycles, then -> DRAIN, row=0.
//   DRAIN  in_rdy=0, c_val=1. Accepted row does row++. Acceptance of row DIM-1 clears all accumulators -> IDLE.
//  Gaps: in_val low in IDLE/LOAD is legal. A bubble with valid tag 0 enters the skew.
//  Skew: a_in[i] passes i delay regs; b_in[j] passes j delay regs. Each value carries a valid tag.
//  Cell (i,j): A flows right, B flows down, one reg per hop.
//   acc += a*b only when the incoming A tag and B tag are both 1. Tags from one beat always coincide.
//  Latency: last product lands in cell (DIM-1,DIM-1) within 2*DIM-2 cycles of the last accepted beat.
//   The FLUSH length 2*DIM-1 covers this with one cycle of margin.
//  c_out mirrors acc row `row` combinationally from registered accumulators.
//   c_out and c_row hold stable while c_val&&!c_rdy.
//  Arithmetic: unsigned by default. Full products are zero-extended to ACC_W, so the sum never overflows.
//  in_val while in_rdy=0: ignored, no side effect. c_rdy while c_val=0: ignored.
//  Back-to-back: the IDLE cycle after DRAIN is mandatory. No overlap of load and drain.
//  Async reset mid-operation: the partial matrix is discarded. The next beat after release starts a fresh matrix.
// CONFIGURATION
//  PE_ARRAY_SIGNED_EN defined:
//   operands are two's complement; products and accumulators are sign-extended to ACC_W.
//   ACC_W guard bit covers the (-2^(WIDTH-1))^2*DIM case.
//  PE_ARRAY_SIGNED_EN undefined: unsigned arithmetic as above.
// STRUCTURE
//  pe_array_pkg holds:
//   state_t enum {IDLE,LOAD,FLUSH,DRAIN}, logic [1:0]
//   function acc_w(dim,width) returning the ACC_W default
//  Sub-module pe_mac_cell, one per grid point, DIMxDIM instances.
//   Holds A/B forward regs, valid tags, accumulator, and a synchronous clear input.
//  Top level holds the FSM, kcnt/fcnt/row counters, skew triangles and row mux.
// TESTING
//  1 DIM=4,WIDTH=8: A=identity, B[k][j]=4k+j+1, 4 beats back-to-back, c_rdy=1
//    -> rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, c_row 0..3.
//  2 All operands 255 -> every c_out element 260100. No overflow at ACC_W=19.
//  3 Same as 1 but in_val=0 for 3 cycles between beats 1 and 2 -> identical C rows. in_rdy stays 1 through gaps.
//  4 c_rdy toggled 1010..., held 0 for 5 cycles on row 2
//    -> c_out/c_row stable while stalled, each row seen exactly once, then busy=0.
//  5 rst_n asserted mid-DRAIN after row 1 -> outputs zero immediately.
//    A new matrix A=B=all-ones -> every element 4.
//  6 PE_ARRAY_SIGNED_EN, all operands -128 -> every element 65536. With A=-1s, B=+1s -> every element -4.

Source files
------------

// File: rtl/pe_array_pkg.sv
// ---------------------------------------------------------------------------
// pe_array_pkg
//  Shared types and helpers for the pe_array_nxn systolic matrix multiplier.
//   state_t : controller states (IDLE, LOAD, FLUSH, DRAIN)
//   acc_w() : default accumulator width for a DIM x DIM array of WIDTH-bit
//             operands: full product width, plus log2(DIM) bits of growth,
//             plus one guard bit.
// ---------------------------------------------------------------------------
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int acc_w(input int dim, input int width);
        return 2 * width + $clog2(dim) + 1;
    endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// ---------------------------------------------------------------------------
// pe_mac_cell
//  One grid point of the output-stationary systolic array. A values move one
//  cell to the right per clock and B values one cell down per clock, each with
//  a valid tag. The local accumulator adds a*b when both incoming tags are set.
//
//  Build option: PE_ARRAY_SIGNED_EN
//   defined   -> operands are two's complement, product sign-extended
//   undefined -> operands unsigned, product zero-extended
//
//  Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clr_i    in   synchronous accumulator clear (wins over accumulate)
//   a_i      in   A operand from the left neighbour / skew chain
//   a_vld_i  in   valid tag for a_i
//   b_i      in   B operand from the upper neighbour / skew chain
//   b_vld_i  in   valid tag for b_i
//   a_o      out  registered A forwarded to the right
//   a_vld_o  out  registered A tag forwarded to the right
//   b_o      out  registered B forwarded downwards
//   b_vld_o  out  registered B tag forwarded downwards
//   acc_o    out  accumulator value
// ---------------------------------------------------------------------------
module pe_mac_cell
    import pe_array_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             a_vld_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             b_vld_i,
    output logic [WIDTH-1:0] a_o,
    output logic             a_vld_o,
    output logic [WIDTH-1:0] b_o,
    output logic             b_vld_o,
    output logic [ACC_W-1:0] acc_o
);

    logic [WIDTH-1:0]   a_q;
    logic               a_vld_q;
    logic [WIDTH-1:0]   b_q;
    logic               b_vld_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [2*WIDTH-1:0] prod_full;
    logic [ACC_W-1:0]   prod_ext;

    // Operands are widened to 2*WIDTH before multiplying so the low 2*WIDTH
    // bits of the product are exact in both number systems.
`ifdef PE_ARRAY_SIGNED_EN
    assign prod_full = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod_ext  = {{(ACC_W-2*WIDTH){prod_full[2*WIDTH-1]}}, prod_full};
`else
    assign prod_full = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    assign prod_ext  = {{(ACC_W-2*WIDTH){1'b0}}, prod_full};
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (a_vld_i && b_vld_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            a_vld_q <= 1'b0;
            b_q     <= '0;
            b_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_i;
            a_vld_q <= a_vld_i;
            b_q     <= b_i;
            b_vld_q <= b_vld_i;
            acc_q   <= acc_d;
        end
    end

    assign a_o     = a_q;
    assign a_vld_o = a_vld_q;
    assign b_o     = b_q;
    assign b_vld_o = b_vld_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/pe_array_nxn.sv
// ---------------------------------------------------------------------------
// pe_array_nxn
//  DIM x DIM output-stationary systolic matrix multiplier, C = A*B.
//  One k-beat per input handshake carries column k of A and row k of B.
//  Skew triangles diagonalise the beats into the MAC grid; after a fixed
//  flush the C rows are drained one per output handshake. One matrix in
//  flight at a time.
//
//  Build option: PE_ARRAY_SIGNED_EN (two's complement operands when defined,
//  unsigned otherwise).
//
//  Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   a_in    in   a_in[i] = A[i][k]
//   b_in    in   b_in[j] = B[k][j]
//   in_val  in   input beat valid
//   in_rdy  out  input beat accepted when in_val && in_rdy
//   c_out   out  c_out[j] = C[c_row][j]
//   c_row   out  row index of c_out
//   c_val   out  output row valid
//   c_rdy   in   output row taken when c_val && c_rdy
//   busy    out  high in any state but IDLE
// ---------------------------------------------------------------------------
module pe_array_nxn
    import pe_array_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int ACC_W = acc_w(DIM, WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIM-1:0][WIDTH-1:0] a_in,
    input  logic [DIM-1:0][WIDTH-1:0] b_in,
    input  logic                      in_val,
    output logic                      in_rdy,
    output logic [DIM-1:0][ACC_W-1:0] c_out,
    output logic [$clog2(DIM)-1:0]    c_row,
    output logic                      c_val,
    input  logic                      c_rdy,
    output logic                      busy
);

    localparam int CW         = $clog2(DIM);
    localparam int FW         = $clog2(2 * DIM);
    // Last product lands 2*DIM-2 cycles after the final beat; one extra cycle
    // of flush gives margin before the rows are exposed.
    localparam int FLUSH_LAST = 2 * DIM - 2;

    state_t        state_q, state_d;
    logic [CW-1:0] kcnt_q, kcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] row_q, row_d;
    logic          in_rdy_q;
    logic          acc_clr;
    logic          in_fire;

    assign in_fire = in_val && in_rdy_q;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        fcnt_d  = fcnt_q;
        row_d   = row_q;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = LOAD;
                    kcnt_d  = CW'(1);
                end
            end
            LOAD: begin
                if (in_fire) begin
                    if (kcnt_q == CW'(DIM - 1)) begin
                        state_d = FLUSH;
                        kcnt_d  = '0;
                        fcnt_d  = '0;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == FW'(FLUSH_LAST)) begin
                    state_d = DRAIN;
                    fcnt_d  = '0;
                    row_d   = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (c_rdy) begin
                    if (row_q == CW'(DIM - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                        acc_clr = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_rdy is registered from the next state so that it reads 0 while in
    // reset and only rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kcnt_q   <= '0;
            fcnt_q   <= '0;
            row_q    <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kcnt_q   <= kcnt_d;
            fcnt_q   <= fcnt_d;
            row_q    <= row_d;
            in_rdy_q <= (state_d == IDLE) || (state_d == LOAD);
        end
    end

    assign in_rdy = in_rdy_q;
    assign c_val  = (state_q == DRAIN);
    assign busy   = (state_q != IDLE);
    assign c_row  = row_q;

    // ------------------------------------------------------- skew triangles
    // Lane i of A and lane j of B are delayed by i and j cycles respectively.
    // Non-accepted cycles travel as bubbles with a zero tag.
    logic [WIDTH-1:0] a_sk   [DIM];
    logic             a_sk_v [DIM];
    logic [WIDTH-1:0] b_sk   [DIM];
    logic             b_sk_v [DIM];

    genvar gi, gj;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_skew
            if (gi == 0) begin : g_direct
                assign a_sk[gi]   = a_in[gi];
                assign a_sk_v[gi] = in_fire;
                assign b_sk[gi]   = b_in[gi];
                assign b_sk_v[gi] = in_fire;
            end else begin : g_delay
                logic [WIDTH-1:0] a_dly_q [gi];
                logic [WIDTH-1:0] b_dly_q [gi];
                logic [gi-1:0]    a_tag_q;
                logic [gi-1:0]    b_tag_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int d = 0; d < gi; d++) begin
                            a_dly_q[d] <= '0;
                            b_dly_q[d] <= '0;
                        end
                        a_tag_q <= '0;
                        b_tag_q <= '0;
                    end else begin
                        a_dly_q[0] <= a_in[gi];
                        b_dly_q[0] <= b_in[gi];
                        a_tag_q[0] <= in_fire;
                        b_tag_q[0] <= in_fire;
                        for (int d = 1; d < gi; d++) begin
                            a_dly_q[d] <= a_dly_q[d-1];
                            b_dly_q[d] <= b_dly_q[d-1];
                            a_tag_q[d] <= a_tag_q[d-1];
                            b_tag_q[d] <= b_tag_q[d-1];
                        end
                    end
                end

                assign a_sk[gi]   = a_dly_q[gi-1];
                assign a_sk_v[gi] = a_tag_q[gi-1];
                assign b_sk[gi]   = b_dly_q[gi-1];
                assign b_sk_v[gi] = b_tag_q[gi-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------ MAC grid
    logic [WIDTH-1:0] a_h  [DIM][DIM];
    logic             a_hv [DIM][DIM];
    logic [WIDTH-1:0] b_v  [DIM][DIM];
    logic             b_vv [DIM][DIM];
    logic [ACC_W-1:0] acc_g [DIM][DIM];

    generate
        for (gi = 0; gi < DIM; gi++) begin : g_row
            for (gj = 0; gj < DIM; gj++) begin : g_col
                logic [WIDTH-1:0] a_fwd;
                logic             a_fwd_v;
                logic [WIDTH-1:0] b_fwd;
                logic             b_fwd_v;

                if (gj == 0) begin : g_a_entry
                    assign a_h[gi][gj]  = a_sk[gi];
                    assign a_hv[gi][gj] = a_sk_v[gi];
                end
                if (gi == 0) begin : g_b_entry
                    assign b_v[gi][gj]  = b_sk[gj];
                    assign b_vv[gi][gj] = b_sk_v[gj];
                end

                pe_mac_cell #(
                    .WIDTH (WIDTH),
                    .ACC_W (ACC_W)
                ) u_cell (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .clr_i   (acc_clr),
                    .a_i     (a_h[gi][gj]),
                    .a_vld_i (a_hv[gi][gj]),
                    .b_i     (b_v[gi][gj]),
                    .b_vld_i (b_vv[gi][gj]),
                    .a_o     (a_fwd),
                    .a_vld_o (a_fwd_v),
                    .b_o     (b_fwd),
                    .b_vld_o (b_fwd_v),
                    .acc_o   (acc_g[gi][gj])
                );

                // Forward links; cells on the right/bottom edge have nowhere
                // to send their operands.
                if (gj < DIM - 1) begin : g_a_link
                    assign a_h[gi][gj+1]  = a_fwd;
                    assign a_hv[gi][gj+1] = a_fwd_v;
                end else begin : g_a_edge
                    logic [WIDTH:0] a_edge_unused;
                    assign a_edge_unused = {a_fwd_v, a_fwd};
                end
                if (gi < DIM - 1) begin : g_b_link
                    assign b_v[gi+1][gj]  = b_fwd;
                    assign b_vv[gi+1][gj] = b_fwd_v;
                end else begin : g_b_edge
                    logic [WIDTH:0] b_edge_unused;
                    assign b_edge_unused = {b_fwd_v, b_fwd};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------- row mux
    generate
        for (gj = 0; gj < DIM; gj++) begin : g_cout
            assign c_out[gj] = acc_g[row_q][gj];
        end
    endgenerate

endmodule

// File: tb/tb_pe_array_nxn.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pe_array_nxn
//  Table-driven bench for pe_array_nxn (DIM=4, WIDTH=8). Directed entries
//  carry hand-computed C matrices; random entries take C from a plain
//  sum-of-products model. A hand sequence covers reset in the middle of DRAIN.
// ---------------------------------------------------------------------------
module tb_pe_array_nxn;
    import pe_array_pkg::*;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;
    localparam int ACC_W = acc_w(DIM, WIDTH);
    localparam int CW    = $clog2(DIM);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [DIM-1:0][WIDTH-1:0] a_in = '0;
    logic [DIM-1:0][WIDTH-1:0] b_in = '0;
    logic                      in_val = 1'b0;
    logic                      in_rdy;
    logic [DIM-1:0][ACC_W-1:0] c_out;
    logic [CW-1:0]             c_row;
    logic                      c_val;
    logic                      c_rdy = 1'b1;
    logic                      busy;

    pe_array_nxn #(
        .DIM   (DIM),
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .c_out  (c_out),
        .c_row  (c_row),
        .c_val  (c_val),
        .c_rdy  (c_rdy),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a   [DIM][DIM];
        int b   [DIM][DIM];
        int exp [DIM][DIM];
        bit use_model;
        int gap;
        int stall;
        bit junk;
    } vec_t;

    vec_t tbl [16];
    int   n_vec = 0;

    int cur_a [DIM][DIM];
    int cur_b [DIM][DIM];
    int exp_c [DIM][DIM];

    task automatic check(input string what, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", what, got, exp);
        end
    endtask

    // Operand interpretation of an 8-bit value.
    function automatic longint opnd(input int v);
        int t;
        t = v & 255;
`ifdef PE_ARRAY_SIGNED_EN
        if (t >= 128) t = t - 256;
`endif
        return longint'(t);
    endfunction

    task automatic run_model();
        longint s;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) s += opnd(cur_a[i][k]) * opnd(cur_b[k][j]);
                exp_c[i][j] = int'(s);
            end
        end
    endtask

    task automatic wait_in_rdy();
        int n;
        n = 0;
        while (!in_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("in_rdy_wait", in_rdy, 1);
    endtask

    task automatic send_matrix(input int gap, input bit junk);
        for (int k = 0; k < DIM; k++) begin
            wait_in_rdy();
            in_val = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                a_in[i] = WIDTH'(cur_a[i][k]);
                b_in[i] = WIDTH'(cur_b[k][i]);
            end
            @(negedge clk);
            in_val = 1'b0;
            a_in   = '0;
            b_in   = '0;
            if (k == 0) check("busy_after_first_beat", busy, 1);
            if (k == 0) begin
                for (int g = 0; g < gap; g++) begin
                    check("in_rdy_during_gap", in_rdy, 1);
                    @(negedge clk);
                end
            end
        end
        if (junk) begin
            // Beats offered while the array is flushing must be ignored.
            in_val = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                a_in[i] = WIDTH'($urandom_range(0, 255));
                b_in[i] = WIDTH'($urandom_range(0, 255));
            end
            for (int g = 0; g < 5; g++) begin
                check("in_rdy_low_in_flush", in_rdy, 0);
                @(negedge clk);
            end
            in_val = 1'b0;
            a_in   = '0;
            b_in   = '0;
        end
    endtask

    task automatic collect(input int stall);
        int got;
        int hold;
        int cyc;
        bit prev_stall;
        logic [DIM-1:0][ACC_W-1:0] prev_out;
        logic [CW-1:0] prev_row;
        logic [ACC_W-1:0] e;
        got = 0; hold = 0; cyc = 0; prev_stall = 1'b0;
        prev_out = '0; prev_row = '0;
        while (got < DIM && cyc < 300) begin
            if (stall == 0) begin
                c_rdy = 1'b1;
            end else if (stall == 1) begin
                if (c_val && c_row == CW'(2) && hold < 5) begin
                    c_rdy = 1'b0;
                    hold++;
                end else begin
                    c_rdy = (cyc % 2 == 0);
                end
            end else begin
                c_rdy = 1'($urandom_range(0, 1));
            end
            if (prev_stall) begin
                check("c_row_stable", c_row, prev_row);
                for (int j = 0; j < DIM; j++) check("c_out_stable", c_out[j], prev_out[j]);
            end
            if (c_val && c_rdy) begin
                check("c_row_order", c_row, got);
                for (int j = 0; j < DIM; j++) begin
                    e = ACC_W'(exp_c[got][j]);
                    check($sformatf("c_out[%0d][%0d]", got, j), c_out[j], e);
                end
                got++;
            end
            prev_stall = c_val && !c_rdy;
            prev_out   = c_out;
            prev_row   = c_row;
            cyc++;
            @(negedge clk);
        end
        check("rows_drained", got, DIM);
        check("busy_after_drain", busy, 0);
        check("c_val_after_drain", c_val, 0);
        c_rdy = 1'b1;
    endtask

    task automatic add_vec(input vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    initial begin
        vec_t v;

        // ------------------------------------------------ reset values
        repeat (2) @(negedge clk);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_c_val", c_val, 0);
        check("rst_c_row", c_row, 0);
        check("rst_busy", busy, 0);
        for (int j = 0; j < DIM; j++) check("rst_c_out", c_out[j], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ------------------------------------------------ vector table
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                v.a[i][j]   = (i == j) ? 1 : 0;
                v.b[i][j]   = 4 * i + j + 1;
                v.exp[i][j] = 4 * i + j + 1;
            end
        v.use_model = 1'b0; v.gap = 0; v.stall = 0; v.junk = 1'b0;
        add_vec(v);                                // identity, back-to-back
        v.gap = 3;
        add_vec(v);                                // 3-cycle gap after beat 1
        v.gap = 0; v.stall = 1;
        add_vec(v);                                // output stalls
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                v.a[i][j] = 255; v.b[i][j] = 255; v.exp[i][j] = 260100;
            end
        v.stall = 0;
        add_vec(v);                                // unsigned worst case
`ifdef PE_ARRAY_SIGNED_EN
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                v.a[i][j] = 128; v.b[i][j] = 128; v.exp[i][j] = 65536;
            end
        add_vec(v);                                // (-128)*(-128)*4
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                v.a[i][j] = 255; v.b[i][j] = 1; v.exp[i][j] = -4;
            end
        add_vec(v);                                // (-1)*(+1)*4
`endif
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    v.a[i][j]   = int'($urandom_range(0, 255));
                    v.b[i][j]   = int'($urandom_range(0, 255));
                    v.exp[i][j] = 0;
                end
            v.use_model = 1'b1;
            v.gap       = int'($urandom_range(0, 2));
            v.stall     = 2;
            v.junk      = 1'b1;
            add_vec(v);
        end

        for (int t = 0; t < n_vec; t++) begin
            cur_a = tbl[t].a;
            cur_b = tbl[t].b;
            if (tbl[t].use_model) run_model();
            else exp_c = tbl[t].exp;
            send_matrix(tbl[t].gap, tbl[t].junk);
            collect(tbl[t].stall);
            $display("matrix %0d: gap=%0d stall_mode=%0d junk=%0d C[0][0]=%0d checks=%0d",
                     t, tbl[t].gap, tbl[t].stall, tbl[t].junk, exp_c[0][0], n_checks);
        end

        // ------------------------------------- reset in the middle of DRAIN
        cur_a = tbl[0].a;
        cur_b = tbl[0].b;
        exp_c = tbl[0].exp;
        send_matrix(0, 1'b0);
        begin
            int n;
            n = 0;
            while (!c_val && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("c_val_wait", c_val, 1);
        end
        c_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            check("pre_rst_row", c_row, r);
            check("pre_rst_c00", c_out[0], exp_c[r][0]);
            @(negedge clk);
        end
        c_rdy = 1'b0;
        check("pre_rst_row2", c_row, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_c_val", c_val, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_rdy", in_rdy, 0);
        check("midrst_c_row", c_row, 0);
        for (int j = 0; j < DIM; j++) check("midrst_c_out", c_out[j], 0);
        @(negedge clk);
        rst_n = 1'b1;
        c_rdy = 1'b1;
        @(negedge clk);
        $display("reset during drain: outputs cleared, checks=%0d", n_checks);

        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                cur_a[i][j] = 1; cur_b[i][j] = 1; exp_c[i][j] = 4;
            end
        send_matrix(0, 1'b0);
        collect(0);
        $display("matrix after reset: all-ones, C[0][0]=%0d checks=%0d", exp_c[0][0], n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
